// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared constants for the multiply/divide unit: the op-field width, the
// mdu* operation codes driven by decode, and the FSM state encodings.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] mduMult  = 3'd0;
    localparam logic [OP_W-1:0] mduMultu = 3'd1;
    localparam logic [OP_W-1:0] mduDiv   = 3'd2;
    localparam logic [OP_W-1:0] mduDivu  = 3'd3;
    localparam logic [OP_W-1:0] mduMthi  = 3'd4;
    localparam logic [OP_W-1:0] mduMtlo  = 3'd5;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_CALC = 2'd1;
    localparam logic [ST_W-1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// One radix-2 iteration of the multi-cycle multiply/divide datapath.
// The 2*WIDTH accumulator is shared by both modes:
//   multiply : {partial product high, multiplier shifting out the bottom}
//   divide   : {partial remainder, dividend/quotient shifting out the top}
// Ports:
//   is_div_i  1        1 = restoring divide step, 0 = shift-add multiply step
//   opnd_i    WIDTH    multiplicand magnitude (mult) or divisor magnitude (div)
//   acc_i     2*WIDTH  current accumulator
//   acc_o     2*WIDTH  accumulator after this iteration
// -----------------------------------------------------------------------------
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     opnd_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set; the extra bit keeps the carry for the shift.
    assign sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

    // Divide: partial remainder shifted left with the next dividend bit,
    // kept one bit wider so the borrow (bit WIDTH) tells us whether it fits.
    assign trial = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};

    always_comb begin
        acc_o = {sum, acc_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (!trial[WIDTH]) begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu
// Multi-cycle MIPS multiply/divide unit sitting beside the execute-stage ALU.
// Runs MULT/MULTU/DIV/DIVU over WIDTH iterations plus one sign fix-up cycle,
// implements MTHI/MTLO, and owns the architectural HI/LO registers.
// Ports:
//   clk     1      clock
//   rst_n   1      asynchronous active-low reset
//   start   1      request strobe, only looked at while idle
//   op      OP_W   operation code (mdu* constants)
//   a       WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data
//   b       WIDTH  rt operand: multiplier / divisor
//   cancel  1      abort in-flight operation (also blocks a start while idle)
//   busy    1      operation in flight; decode stalls HI/LO readers on it
//   done    1      one-cycle pulse when HI/LO take a MULT/DIV result
//   hi, lo  WIDTH  HI/LO registers
// -----------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [ST_W-1:0]     state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                done_q, done_d;

    logic                is_signed;
    logic                a_neg, b_neg;
    logic [WIDTH-1:0]    mag_a, mag_b;
    logic [2*WIDTH-1:0]  acc_step;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_fix, rem_fix;

    // Operand magnitudes: only the signed ops take absolute values.
    assign is_signed = (op == mduMult) || (op == mduDiv);
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div_i (is_div_q),
        .opnd_i   (opnd_q),
        .acc_i    (acc_q),
        .acc_o    (acc_step)
    );

    // Sign fix-up applied in FIX. The divide-by-zero preset clears both
    // flags so its raw lo=all-ones / hi=a values pass through untouched.
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state logic: idle accept/MTHI/MTLO, per-cycle iteration, fix-up
    // and writeback. cancel wins over everything, including a FIX completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        mduMthi: hi_d = a;
                        mduMtlo: lo_d = a;
                        mduMult, mduMultu: begin
                            is_div_d  = 1'b0;
                            opnd_d    = mag_a;
                            acc_d     = {{WIDTH{1'b0}}, mag_b};
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_CALC;
                        end
                        mduDiv, mduDivu: begin
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            if (b == '0) begin
                                opnd_d    = '0;
                                acc_d     = {a, {WIDTH{1'b1}}};
                                neg_res_d = 1'b0;
                                neg_rem_d = 1'b0;
                                state_d   = ST_FIX;
                            end else begin
                                opnd_d    = mag_b;
                                acc_d     = {{WIDTH{1'b0}}, mag_a};
                                neg_res_d = a_neg ^ b_neg;
                                neg_rem_d = a_neg;
                                state_d   = ST_CALC;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers; reset clears everything,
    // including a half-finished iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu
// Directed bench for the multiply/divide unit: reset, MTHI/MTLO, the four
// MULT/DIV flavours including the INT_MIN/-1 and divide-by-zero corners,
// ignored start while busy, cancel, and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_mdu;
    import mdu_pkg::*;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [OP_W-1:0]   op = '0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              cancel = 1'b0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int testsRun = 0;
    int testsFailed = 0;

    mdu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Issue one op for a single cycle, then count busy cycles and done
    // pulses (sampled on falling edges) until the unit goes idle again.
    task automatic applyStimulus(input logic [OP_W-1:0] opCode, input logic [WIDTH-1:0] aVal,
                                 input logic [WIDTH-1:0] bVal, output int busyCycles, output int doneCount);
        busyCycles = 0;
        doneCount  = 0;
        @(negedge clk);
        op = opCode; a = aVal; b = bVal; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) doneCount++;
            if (!busy) break;
            busyCycles++;
            @(negedge clk);
        end
        @(negedge clk);
        if (done) doneCount++;
    endtask

    task automatic test_reset();
        #2;
        testsRun++;
        if ({busy, done} !== 2'b00 || hi !== '0 || lo !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset: busy=%b done=%b hi=%h lo=%h, want 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        op = mduMthi; a = 32'h1357_9BDF; start = 1'b1;
        @(negedge clk);
        op = mduMtlo; a = 32'h2468_ACE0;
        @(negedge clk);
        start = 1'b0;
        testsRun++;
        if (hi !== 32'h1357_9BDF || lo !== 32'h2468_ACE0 || busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mthi_mtlo: hi=%h lo=%h busy=%b done=%b, want 13579bdf/2468ace0/0/0", hi, lo, busy, done);
        end
        // Unused op codes and a cancelled start leave HI/LO alone.
        op = 3'd6; a = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        op = mduMthi; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        testsRun++;
        if (hi !== 32'h1357_9BDF || lo !== 32'h2468_ACE0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL unused_op_cancel: hi=%h lo=%h busy=%b, want 13579bdf/2468ace0/0", hi, lo, busy);
        end
    endtask

    task automatic test_mult();
        int bc, dc;
        applyStimulus(mduMult, 32'd7, 32'hFFFF_FFFD, bc, dc);
        testsRun++;
        if (bc !== 33) begin
            testsFailed++;
            $display("[TB] FAIL mult_busy: got %0d cycles, want 33", bc);
        end
        testsRun++;
        if (dc !== 1) begin
            testsFailed++;
            $display("[TB] FAIL mult_done: got %0d pulses, want 1", dc);
        end
        testsRun++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            testsFailed++;
            $display("[TB] FAIL mult_result: hi=%h lo=%h, want ffffffff/ffffffeb", hi, lo);
        end
        applyStimulus(mduMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        testsRun++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || dc !== 1) begin
            testsFailed++;
            $display("[TB] FAIL multu_result: hi=%h lo=%h done=%0d, want fffffffe/00000001/1", hi, lo, dc);
        end
        applyStimulus(mduMultu, 32'h0001_0000, 32'h0003_0005, bc, dc);
        testsRun++;
        if (hi !== 32'h0000_0003 || lo !== 32'h0005_0000) begin
            testsFailed++;
            $display("[TB] FAIL multu_shift: hi=%h lo=%h, want 00000003/00050000", hi, lo);
        end
    endtask

    task automatic test_div();
        int bc, dc;
        applyStimulus(mduDiv, 32'hFFFF_FFF9, 32'd2, bc, dc);
        testsRun++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || bc !== 33 || dc !== 1) begin
            testsFailed++;
            $display("[TB] FAIL div_neg: lo=%h hi=%h busy=%0d done=%0d, want fffffffd/ffffffff/33/1", lo, hi, bc, dc);
        end
        applyStimulus(mduDiv, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
        testsRun++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL div_overflow: lo=%h hi=%h, want 80000000/00000000", lo, hi);
        end
        applyStimulus(mduDiv, 32'd100, 32'hFFFF_FFF9, bc, dc);
        testsRun++;
        if (lo !== 32'hFFFF_FFF2 || hi !== 32'd2) begin
            testsFailed++;
            $display("[TB] FAIL div_negdivisor: lo=%h hi=%h, want fffffff2/00000002", lo, hi);
        end
        applyStimulus(mduDivu, 32'hFFFF_FFF9, 32'd2, bc, dc);
        testsRun++;
        if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL divu: lo=%h hi=%h, want 7ffffffc/00000001", lo, hi);
        end
    endtask

    task automatic test_div_zero();
        int bc, dc;
        applyStimulus(mduDivu, 32'h0000_1234, 32'd0, bc, dc);
        testsRun++;
        if (bc !== 1) begin
            testsFailed++;
            $display("[TB] FAIL divzero_busy: got %0d cycles, want 1", bc);
        end
        testsRun++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234 || dc !== 1) begin
            testsFailed++;
            $display("[TB] FAIL divzero_result: lo=%h hi=%h done=%0d, want ffffffff/00001234/1", lo, hi, dc);
        end
        applyStimulus(mduDiv, 32'hFFFF_FFF0, 32'd0, bc, dc);
        testsRun++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF0 || bc !== 1) begin
            testsFailed++;
            $display("[TB] FAIL divzero_signed: lo=%h hi=%h busy=%0d, want ffffffff/fffffff0/1", lo, hi, bc);
        end
    endtask

    task automatic test_interference();
        int doneSeen;
        @(negedge clk);
        op = mduMthi; a = 32'hAAAA_5555; start = 1'b1;
        @(negedge clk);
        op = mduMtlo; a = 32'h0F0F_0F0F;
        @(negedge clk);
        op = mduMult; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        // Cycle 0 was the accepting edge; step to cycle 5.
        repeat (4) @(negedge clk);
        op = mduMtlo; a = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        testsRun++;
        if (lo !== 32'h0F0F_0F0F || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ignored_start: lo=%h busy=%b, want 0f0f0f0f/1", lo, busy);
        end
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hAAAA_5555 || lo !== 32'h0F0F_0F0F) begin
            testsFailed++;
            $display("[TB] FAIL cancel: busy=%b done=%b hi=%h lo=%h, want 0/0/aaaa5555/0f0f0f0f", busy, done, hi, lo);
        end
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        testsRun++;
        if (doneSeen !== 0 || lo !== 32'h0F0F_0F0F) begin
            testsFailed++;
            $display("[TB] FAIL cancel_quiet: activity=%0d lo=%h, want 0/0f0f0f0f", doneSeen, lo);
        end
        // Asynchronous reset in the middle of an iteration.
        op = mduMultu; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: hi=%h lo=%h busy=%b done=%b, want 0/0/0/0", hi, lo, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        testsRun++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_idle: hi=%h lo=%h busy=%b, want 0/0/0", hi, lo, busy);
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc;
        applyStimulus(mduMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        applyStimulus(mduDivu, 32'd1000, 32'd7, bc, dc);
        testsRun++;
        if (lo !== 32'd142 || hi !== 32'd6 || bc !== 33 || dc !== 1) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back: lo=%h hi=%h busy=%0d done=%0d, want 0000008e/00000006/33/1", lo, hi, bc, dc);
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_interference();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
